key_step_ctrl: RTL

Parametrised, multi-channel push-button conditioner and processor single-step/run controller.
- Per key: synchronises, debounces and edge-detects N_KEYS raw board keys.
- Produces a one-cycle processor step enable, either from a manual step key or from a free-running divider in run mode.
- Keeps a step counter for the debug display mux.
- Replaces the single-channel sync/filter pair in front of the processor; the processor is clocked from Clk and qualified by step_en.

---
 rtl/key_step_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/key_step_ctrl.sv
// key_step_ctrl: multi-channel push-button conditioner plus processor
// single-step / free-run controller.
// Each key is synchronised, debounced and edge-detected. step_en is a
// one-cycle enable, driven either by the manual step key or by a
// free-running divider in run mode. step_count counts issued steps.
// Optional macro STEP_REPEAT_EN: holding the step key in step mode
// auto-repeats step_en after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles. When the macro is undefined, the repeat logic
// is not built.
module key_step_ctrl #(
  parameter int N_KEYS          = 4,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_IDX        = 0,
  parameter int MODE_IDX        = 1,
  parameter int RUN_DIV         = 25000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              run_mode,
  output logic              step_en,
  output logic [15:0]       step_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
  // A raw line with no key pressed reads high on active-low boards.
  localparam logic [N_KEYS-1:0] RAW_IDLE = (KEY_ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_sync;
  logic [CW-1:0]     r_db_cnt [N_KEYS];
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic              r_run_mode;
  logic [DW-1:0]     r_div;
  logic              r_step_en;
  logic [15:0]       r_step_count;
  logic              w_mode_press;
  logic              w_step_press;
  logic              w_div_fire;
  logic              w_rep_fire;

  // Two-flop synchroniser; resets to the released level so that reset produces no press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Normalise polarity after synchronisation: 1 = pressed.
  assign w_sync = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // Per-channel debounce. A level change is accepted only after DEBOUNCE_CYCLES stable cycles; press and release pulses are registered together with the level change.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_KEYS; i++) r_db_cnt[i] <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (w_sync[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i]  <= '0;
          r_level[i]   <= w_sync[i];
          r_press[i]   <= w_sync[i];
          r_release[i] <= ~w_sync[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_mode_press = r_press[MODE_IDX];
  assign w_step_press = r_press[STEP_IDX];
  assign w_div_fire   = r_run_mode && (r_div == DIV_LAST);

`ifdef STEP_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX);
  localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

  logic          r_rep_active;
  logic          r_rep_first;
  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_target;

  assign w_rep_target = r_rep_first ? REP_FIRST_LAST : REP_NEXT_LAST;
  assign w_rep_fire   = r_rep_active && r_level[STEP_IDX] && !r_run_mode &&
                        (r_rep_cnt == w_rep_target);

  // Auto-repeat timer. It counts cycles since the step press, and is cancelled by a release or a mode toggle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rep_active <= 1'b0;
      r_rep_first  <= 1'b0;
      r_rep_cnt    <= '0;
    end else if (w_mode_press || !r_level[STEP_IDX]) begin
      r_rep_active <= 1'b0;
      r_rep_first  <= 1'b0;
      r_rep_cnt    <= '0;
    end else if (w_step_press && !r_run_mode) begin
      // The press cycle itself counts as cycle 0 of the initial delay.
      r_rep_active <= 1'b1;
      r_rep_first  <= 1'b1;
      r_rep_cnt    <= RW'(1);
    end else if (r_rep_active) begin
      if (w_rep_fire) begin
        r_rep_first <= 1'b0;
        r_rep_cnt   <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Mode toggle, run divider, step pulse and step counter. The step source is chosen by the mode before any toggle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_run_mode   <= 1'b0;
      r_div        <= '0;
      r_step_en    <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_run_mode <= r_run_mode ^ w_mode_press;
      if (!r_run_mode || w_mode_press || w_div_fire) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_step_en    <= (w_step_press && !r_run_mode) || w_div_fire || w_rep_fire;
      r_step_count <= r_step_count + 16'(r_step_en);
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign run_mode    = r_run_mode;
  assign step_en     = r_step_en;
  assign step_count  = r_step_count;

endmodule
